// File: rtl/pll_lock_supervisor_pkg.sv
// PLL lock supervisor shared types and default timing.
// State encoding plus 20 MHz reference timing constants.
package pll_lock_supervisor_pkg;

  typedef enum logic [2:0] {
    HOLD,
    WAIT_LOCK,
    STABLE,
    RUN,
    FAIL
  } state_t;

  // 1 us PLL reset at 20 MHz
  localparam int DEF_RESET_CYCLES = 20;
  // 100 us lock window at 20 MHz
  localparam int DEF_LOCK_TIMEOUT_CYCLES = 2000;
  // 10 us of clean lock before release
  localparam int DEF_LOCK_STABLE_CYCLES = 200;
  localparam int DEF_DROP_FILTER = 4;
  localparam int DEF_MAX_ATTEMPTS = 4;

  function automatic int cw(input int n);
    return (n < 2) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/pll_lock_supervisor_sync_2ff.sv
// Generic 2-flop synchronizer, async active-low reset to 0.
// Ports: clk, rst_n, d (async input), q (synchronized).
module sync_2ff #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pll_lock_supervisor.sv
// Sequences PLL reset/bypass, qualifies LOCK, retries, falls back.
// Ports: REFERENCECLK, RESET(n), LOCK, CLEAR -> PLL_RESETB,
// PLL_BYPASS, READY, LOCK_LOST, FAILED, ATTEMPTS.
module pll_lock_supervisor
  import pll_lock_supervisor_pkg::*;
#(
  parameter int RESET_CYCLES        = DEF_RESET_CYCLES,
  parameter int LOCK_TIMEOUT_CYCLES = DEF_LOCK_TIMEOUT_CYCLES,
  parameter int LOCK_STABLE_CYCLES  = DEF_LOCK_STABLE_CYCLES,
  parameter int DROP_FILTER         = DEF_DROP_FILTER,
  parameter int MAX_ATTEMPTS        = DEF_MAX_ATTEMPTS,
  localparam int AW = $clog2(MAX_ATTEMPTS + 1)
) (
  input  logic          REFERENCECLK,
  input  logic          RESET,
  input  logic          LOCK,
  input  logic          CLEAR,
  output logic          PLL_RESETB,
  output logic          PLL_BYPASS,
  output logic          READY,
  output logic          LOCK_LOST,
  output logic          FAILED,
  output logic [AW-1:0] ATTEMPTS
);

  localparam int RW = cw(RESET_CYCLES);
  localparam int TW = cw(LOCK_TIMEOUT_CYCLES);
  localparam int SW = cw(LOCK_STABLE_CYCLES);
  localparam int DW = cw(DROP_FILTER);

  localparam logic [RW-1:0] RLAST = RW'(RESET_CYCLES - 1);
  localparam logic [TW-1:0] TLAST = TW'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [SW-1:0] SLAST = SW'(LOCK_STABLE_CYCLES - 1);
  localparam logic [DW-1:0] DLAST = DW'(DROP_FILTER - 1);
  localparam logic [AW-1:0] AMAX  = AW'(MAX_ATTEMPTS);

  logic          lock_s;
  state_t        state, state_n;
  logic [RW-1:0] rcnt, rcnt_n;
  logic [TW-1:0] tcnt, tcnt_n;
  logic [SW-1:0] scnt, scnt_n;
  logic [DW-1:0] dcnt, dcnt_n;
  logic [AW-1:0] att_n;
  logic          lost_n;

  sync_2ff #(.W(1)) u_lock_sync (
    .clk   (REFERENCECLK),
    .rst_n (RESET),
    .d     (LOCK),
    .q     (lock_s)
  );

  always_ff @(posedge REFERENCECLK or negedge RESET) begin
    if (!RESET) begin
      state      <= HOLD;
      rcnt       <= '0;
      tcnt       <= '0;
      scnt       <= '0;
      dcnt       <= '0;
      ATTEMPTS   <= '0;
      LOCK_LOST  <= 1'b0;
      PLL_RESETB <= 1'b0;
      PLL_BYPASS <= 1'b0;
      READY      <= 1'b0;
      FAILED     <= 1'b0;
    end else begin
      state      <= state_n;
      rcnt       <= rcnt_n;
      tcnt       <= tcnt_n;
      scnt       <= scnt_n;
      dcnt       <= dcnt_n;
      ATTEMPTS   <= att_n;
      LOCK_LOST  <= lost_n;
      // outputs follow the state being entered, so they
      // change on the same edge as the transition
      PLL_RESETB <= (state_n != HOLD);
      PLL_BYPASS <= (state_n == FAIL);
      READY      <= (state_n == RUN) || (state_n == FAIL);
      FAILED     <= (state_n == FAIL);
    end
  end

  always_comb begin
    state_n = state;
    rcnt_n  = rcnt;
    tcnt_n  = tcnt;
    scnt_n  = scnt;
    dcnt_n  = dcnt;
    att_n   = ATTEMPTS;
    lost_n  = LOCK_LOST;
    if (CLEAR) lost_n = 1'b0;
    unique case (state)
      HOLD: begin
        if (rcnt == RLAST) begin
          state_n = WAIT_LOCK;
          rcnt_n  = '0;
          tcnt_n  = '0;
          scnt_n  = '0;
        end else begin
          rcnt_n = rcnt + 1'b1;
        end
      end
      WAIT_LOCK, STABLE: begin
        tcnt_n = tcnt + 1'b1;
        // timeout beats a simultaneous stable completion
        if (tcnt == TLAST) begin
          att_n   = ATTEMPTS + 1'b1;
          tcnt_n  = '0;
          scnt_n  = '0;
          rcnt_n  = '0;
          state_n = (att_n == AMAX) ? FAIL : HOLD;
        end else if (state == WAIT_LOCK) begin
          if (lock_s) begin
            state_n = STABLE;
            scnt_n  = '0;
          end
        end else if (!lock_s) begin
          state_n = WAIT_LOCK;
          scnt_n  = '0;
        end else if (scnt == SLAST) begin
          state_n = RUN;
          att_n   = '0;
          dcnt_n  = '0;
        end else begin
          scnt_n = scnt + 1'b1;
        end
      end
      RUN: begin
        if (lock_s) begin
          dcnt_n = '0;
        end else if (dcnt == DLAST) begin
          // set beats a coincident CLEAR
          state_n = HOLD;
          lost_n  = 1'b1;
          rcnt_n  = '0;
          dcnt_n  = '0;
        end else begin
          dcnt_n = dcnt + 1'b1;
        end
      end
      FAIL: begin
        if (CLEAR) begin
          state_n = HOLD;
          att_n   = '0;
          rcnt_n  = '0;
        end
      end
      default: state_n = HOLD;
    endcase
  end

endmodule

// File: doc/pll_lock_supervisor.md
Name: pll_lock_supervisor

Overview:
Sequences the iCE40 PLL that multiplies the 20 MHz reference to 100 MHz. It drives the PLL's active-low reset and bypass, watches the PLL LOCK output, and declares the 100 MHz clock usable only after lock has been stable for a qualified time. It retries on lock timeout and falls back to bypass (20 MHz passthrough) after repeated failure. It runs entirely on the 20 MHz reference clock, which is valid before the PLL locks.

Parameters:
RESET_CYCLES, 20, cycles PLL_RESETB is held low per attempt (1 us at 20 MHz)
LOCK_TIMEOUT_CYCLES, 2000, maximum cycles in WAIT_LOCK+STABLE before an attempt fails (100 us)
LOCK_STABLE_CYCLES, 200, consecutive synced-LOCK-high cycles required before READY
DROP_FILTER, 4, consecutive synced-LOCK-low cycles in RUN treated as loss of lock
MAX_ATTEMPTS, 4, failed attempts before FAIL/bypass

Ports:
REFERENCECLK  in   1  20 MHz reference clock; only clock
RESET         in   1  asynchronous, active-low reset
LOCK          in   1  PLL lock, asynchronous to REFERENCECLK
CLEAR         in   1  synchronous one-cycle pulse: clear LOCK_LOST; restart from FAIL
PLL_RESETB    out  1  to PLL RESETB, active low
PLL_BYPASS    out  1  to PLL BYPASS
READY         out  1  downstream clock domain may leave reset
LOCK_LOST     out  1  sticky: lock dropped while in RUN
FAILED        out  1  MAX_ATTEMPTS exhausted, PLL bypassed
ATTEMPTS      out  clog2(MAX_ATTEMPTS+1)  failed attempts since last RUN/CLEAR

Behaviour:
- Reset (RESET=0, asynchronous): state HOLD, counters 0, PLL_RESETB=0, PLL_BYPASS=0, READY=0, LOCK_LOST=0, FAILED=0, ATTEMPTS=0, synchronizer flops 0.
- LOCK passes through a 2-flop synchronizer (lock_s); 2-cycle latency. All decisions use lock_s only.
- All outputs are registered, with no combinational path from inputs.
- HOLD: PLL_RESETB=0; count RESET_CYCLES cycles, then WAIT_LOCK. The timeout counter is cleared on entry.
- WAIT_LOCK: PLL_RESETB=1; timeout counter increments; lock_s=1 -> STABLE (stable counter=0).
- STABLE: stable counter increments while lock_s=1. lock_s=0 -> WAIT_LOCK, stable counter cleared, timeout counter keeps running. Stable count reaching LOCK_STABLE_CYCLES -> RUN; READY=1 from that edge; ATTEMPTS cleared.
- Timeout (counter reaches LOCK_TIMEOUT_CYCLES in WAIT_LOCK or STABLE): ATTEMPTS+1. If the new value equals MAX_ATTEMPTS -> FAIL, else HOLD. Timeout has priority over a simultaneous STABLE completion.
- RUN: READY=1. lock_s low for DROP_FILTER consecutive cycles -> READY=0, LOCK_LOST=1, HOLD. Shorter glitches are ignored; the drop counter clears on lock_s=1.
- FAIL: PLL_BYPASS=1, PLL_RESETB=1, FAILED=1, READY=1 (design runs at 20 MHz passthrough). LOCK is ignored. Exit only by RESET or CLEAR.
- CLEAR: clears LOCK_LOST in any state. In FAIL it also sets ATTEMPTS=0, FAILED=0, PLL_BYPASS=0 and moves to HOLD. CLEAR coincident with a LOCK_LOST set event: the set wins.
- READY deassertion on loss of lock is one registered cycle after the filter completes. Downstream must treat READY as asynchronous to the 100 MHz clock.

Decomposition:
- Shared package: state enum (HOLD, WAIT_LOCK, STABLE, RUN, FAIL) and default timing constants for 20 MHz reference.
- One sub-module: sync_2ff (generic 2-flop synchronizer, reset to 0), reused for LOCK and elsewhere in the codebase.

Test Plan:
- Release RESET, LOCK held 0 -> PLL_RESETB low exactly 20 cycles then 1. READY=0, ATTEMPTS=0.
- LOCK rises at edge N in WAIT_LOCK and stays high -> READY=1 at edge N+2+200. PLL_RESETB=1, ATTEMPTS=0.
- LOCK never rises -> 2020-cycle attempt period. ATTEMPTS steps 1,2,3. After the 4th timeout: FAILED=1, PLL_BYPASS=1, READY=1. CLEAR pulse -> FAILED=0, BYPASS=0, PLL_RESETB=0 for 20 cycles.
- In RUN, LOCK low for 3 cycles -> READY stays 1. LOCK low for 4 cycles -> READY=0, LOCK_LOST=1, PLL_RESETB=0 for 20 cycles. CLEAR -> LOCK_LOST=0.
- In STABLE, LOCK drops after 150 high cycles, then returns -> READY needs a fresh 200 consecutive cycles. LOCK withheld past cycle 2000 -> ATTEMPTS=1, HOLD.
- RESET asserted asynchronously mid-RUN (between clock edges) -> READY=0, PLL_RESETB=0, LOCK_LOST=0 immediately, without waiting for a clock edge.
